jk_cmd_sequencer: RTL

- Upstream command stage for the team's JK flip-flop; drives its J/K inputs.
- Accepts hold/clear/set/toggle commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command on J/K for a programmable number of consecutive cycles.
- Keeps a cycle-exact model of the downstream flop's Q so checkers and neighbouring logic can compare against it.

---
 rtl/jk_cmd_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a downstream JK flop: buffers {J,K} commands in a FIFO,
// replays each one for len+1 cycles and keeps a cycle-exact model of the flop's Q.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_len,
  output logic                     J,
  output logic                     K,
  output logic                     busy,
  output logic                     done,
  output logic                     q_model,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_e;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] len;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  state_e           state_q, state_d;
  logic [1:0]       jk_q, jk_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             q_q, q_d;
  logic             full, empty, push, pop;
  cmd_t             head;

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  // Ready depends only on registered occupancy and reset, never on cmd_valid.
  assign cmd_ready = rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    jk_d    = jk_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        jk_d = 2'b00;
        if (!empty) begin
          pop     = 1'b1;
          jk_d    = head.op;
          rem_d   = head.len;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
        end else begin
          done_d = 1'b1;
          if (!empty) begin
            // Chain straight into the next command without an idle bubble.
            pop   = 1'b1;
            jk_d  = head.op;
            rem_d = head.len;
          end else begin
            jk_d    = 2'b00;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (jk_q)
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      jk_q     <= 2'b00;
      rem_q    <= '0;
      done_q   <= 1'b0;
      q_q      <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      jk_q    <= jk_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      q_q     <= q_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; occupancy and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, len: cmd_len};
  end

  assign J       = jk_q[1];
  assign K       = jk_q[0];
  assign busy    = (state_q == ISSUE);
  assign done    = done_q;
  assign q_model = q_q;
  assign level   = level_q;

endmodule
